// File: rtl/nn_classifier_pkg.sv
// -----------------------------------------------------------------------------
// nn_classifier_pkg
// Shared types, constants and helpers for the fp32 output classifier.
//   state_t       : controller states IDLE / SCAN / DONE
//   FP32_QNAN     : canonical quiet NaN, reported when no runner-up exists
//   FP32_EXP_MAX  : all-ones exponent field (Inf / NaN)
//   is_nan()      : true for exponent all ones with a non-zero mantissa
// -----------------------------------------------------------------------------
package nn_classifier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == FP32_EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/nn_output_classifier_fp32_gt.sv
// -----------------------------------------------------------------------------
// fp32_gt
// Combinational "a > b" for IEEE-754 single values used by the classifier.
// NaN handling is left to the caller: a_nan flags an unordered candidate and
// gt is only meaningful when neither operand is NaN.
// Ordering: +0 == -0, infinities ordered normally, denormals ordered by bits.
// Ports:
//   a, b   in  32  operands
//   gt     out 1   a strictly greater than b
//   a_nan  out 1   a is a NaN
// -----------------------------------------------------------------------------
module fp32_gt
  import nn_classifier_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt,
  output logic        a_nan
);

  logic both_zero;

  assign a_nan     = is_nan(a);
  assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);

  // NOTE: combinational logic uses blocking '=' and assigns a default first,
  // so every path drives the output and no latch is inferred.
  always_comb begin
    gt = 1'b0;
    if (a[31] != b[31]) begin
      // Opposite signs: the positive one wins, except +0 versus -0.
      gt = !a[31] && !both_zero;
    end else if (!a[31]) begin
      gt = a[30:0] > b[30:0];
    end else begin
      // Both negative: the smaller magnitude is the larger value.
      gt = a[30:0] < b[30:0];
    end
  end

endmodule

// File: rtl/nn_output_classifier.sv
// -----------------------------------------------------------------------------
// nn_output_classifier
// Captures a packed fp32 result vector and scans it one element per cycle to
// report the argmax class and its score. NaN elements never win; ties keep the
// lowest index; an all-NaN vector reports index 0 with element 0's bits.
// Optional build macro NN_CLASSIFIER_RUNNER_UP_EN adds the second-largest
// non-NaN element (out_index2 / out_value2, 0 / quiet NaN when none exists).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input vector handshake (in_ready = IDLE)
//   in_data               element i at [32*i +: 32]
//   out_valid/out_ready   result handshake (out_valid = DONE)
//   out_index/out_value   argmax index and fp32 bits, held while out_valid
//   out_index2/out_value2 runner-up (only with NN_CLASSIFIER_RUNNER_UP_EN)
//   busy                  high in SCAN or DONE
// -----------------------------------------------------------------------------
module nn_output_classifier
  import nn_classifier_pkg::*;
#(
  parameter int OUTPUTSIZE = 10,
  parameter int IDXW       = (OUTPUTSIZE > 1) ? $clog2(OUTPUTSIZE) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [32*OUTPUTSIZE-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDXW-1:0]         out_index,
  output logic [31:0]             out_value,
`ifdef NN_CLASSIFIER_RUNNER_UP_EN
  output logic [IDXW-1:0]         out_index2,
  output logic [31:0]             out_value2,
`endif
  output logic                    busy
);

  state_t                   state, state_nxt;
  logic [32*OUTPUTSIZE-1:0] cap;
  logic [IDXW-1:0]          scan_idx;
  logic                     best_ok;
  logic [31:0]              elem;
  logic                     elem_nan, elem_gt, take_best;
  logic                     accept, release_out, last;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;
  assign last        = (scan_idx == IDXW'(OUTPUTSIZE - 1));

  assign elem = cap[32*int'(scan_idx) +: 32];

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)      state_nxt = (OUTPUTSIZE == 1) ? DONE : SCAN;
      SCAN: if (last)        state_nxt = DONE;
      DONE: if (release_out) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Captured vector: the sender may change in_data once accepted.
  // ---------------------------------------------------------------------------
  // NOTE: pure datapath storage has no reset; it is always written on accept
  // before any element is read, so resetting it would only cost area and
  // reset-tree fanout.
  always_ff @(posedge clk) begin
    if (accept) cap <= in_data;
  end

  // ---------------------------------------------------------------------------
  // Best tracking
  // ---------------------------------------------------------------------------
  fp32_gt u_gt_best (
    .a     (elem),
    .b     (out_value),
    .gt    (elem_gt),
    .a_nan (elem_nan)
  );

  // best_ok is low while the held best is still a NaN element 0.
  assign take_best = !elem_nan && (!best_ok || elem_gt);

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx  <= '0;
      best_ok   <= 1'b0;
      out_index <= '0;
      out_value <= '0;
    end else if (accept) begin
      scan_idx  <= IDXW'(1);
      best_ok   <= !is_nan(in_data[31:0]);
      out_index <= '0;
      out_value <= in_data[31:0];
    end else if (state == SCAN) begin
      scan_idx <= scan_idx + IDXW'(1);
      if (take_best) begin
        best_ok   <= 1'b1;
        out_index <= scan_idx;
        out_value <= elem;
      end
    end
  end

`ifdef NN_CLASSIFIER_RUNNER_UP_EN
  // ---------------------------------------------------------------------------
  // Runner-up tracking. A displaced best drops to second together with its
  // validity, so a NaN element 0 pushed out of first place never counts.
  // ---------------------------------------------------------------------------
  logic            sec_ok, sec_ok_n;
  logic [IDXW-1:0] sec_idx_n;
  logic [31:0]     sec_val_n;
  logic            sec_gt, sec_a_nan, take_sec;

  fp32_gt u_gt_sec (
    .a     (elem),
    .b     (out_value2),
    .gt    (sec_gt),
    .a_nan (sec_a_nan)
  );

  assign take_sec = !sec_a_nan && (!sec_ok || sec_gt);

  always_comb begin
    sec_ok_n  = sec_ok;
    sec_idx_n = out_index2;
    sec_val_n = out_value2;
    if (take_best) begin
      sec_ok_n  = best_ok;
      sec_idx_n = out_index;
      sec_val_n = out_value;
    end else if (take_sec) begin
      sec_ok_n  = 1'b1;
      sec_idx_n = scan_idx;
      sec_val_n = elem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_ok     <= 1'b0;
      out_index2 <= '0;
      out_value2 <= '0;
    end else if (accept) begin
      sec_ok     <= 1'b0;
      out_index2 <= '0;
      out_value2 <= FP32_QNAN;
    end else if (state == SCAN) begin
      sec_ok <= sec_ok_n;
      if (last && !sec_ok_n) begin
        // No runner-up exists: report index 0 with the quiet NaN.
        out_index2 <= '0;
        out_value2 <= FP32_QNAN;
      end else begin
        out_index2 <= sec_idx_n;
        out_value2 <= sec_val_n;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nn_output_classifier.sv
// -----------------------------------------------------------------------------
// tb_nn_output_classifier
// Randomised and directed stimulus for nn_output_classifier (4-element and
// 1-element instances) compared against an ordering-key reference model.
// Define NN_CLASSIFIER_RUNNER_UP_EN for both RTL and bench to cover the
// runner-up outputs.
// -----------------------------------------------------------------------------
module tb_nn_output_classifier;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef logic [31:0] vec_t [N];

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0, out_ready = 1'b0;
  logic              in_ready, out_valid, busy;
  logic [32*N-1:0]   in_data = '0;
  logic [IW-1:0]     out_index;
  logic [31:0]       out_value;
  logic              in1_valid = 1'b0, out1_ready = 1'b0;
  logic              in1_ready, out1_valid, busy1;
  logic [31:0]       in1_data = '0;
  logic [0:0]        out1_index;
  logic [31:0]       out1_value;
`ifdef NN_CLASSIFIER_RUNNER_UP_EN
  logic [IW-1:0]     out_index2;
  logic [31:0]       out_value2;
  logic [0:0]        out1_index2;
  logic [31:0]       out1_value2;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  nn_output_classifier #(.OUTPUTSIZE(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_value(out_value),
`ifdef NN_CLASSIFIER_RUNNER_UP_EN
    .out_index2(out_index2), .out_value2(out_value2),
`endif
    .busy(busy)
  );

  nn_output_classifier #(.OUTPUTSIZE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in1_valid), .in_ready(in1_ready), .in_data(in1_data),
    .out_valid(out1_valid), .out_ready(out1_ready),
    .out_index(out1_index), .out_value(out1_value),
`ifdef NN_CLASSIFIER_RUNNER_UP_EN
    .out_index2(out1_index2), .out_value2(out1_value2),
`endif
    .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Signed ordering key: magnitude, negated for negatives (so -0 == +0 == 0).
  function automatic longint m_key(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    return x[31] ? -mag : mag;
  endfunction

  // Earliest maximum among non-NaN elements other than 'skip'; -1 if none.
  function automatic int m_best(input vec_t v, input int skip);
    int b;
    b = -1;
    for (int i = 0; i < N; i++)
      if (i != skip && !m_nan(v[i]) && (b < 0 || m_key(v[i]) > m_key(v[b])))
        b = i;
    return b;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    logic [31:0] s;
    r = $urandom();
    s = $urandom();
    case ($urandom_range(0, 7))
      0:       return {r[31], 8'hFF, r[22:0] | 23'd1};
      1:       return {r[31], 31'd0};
      2:       return {r[31], 8'hFF, 23'd0};
      3:       return {r[31], 8'd0, r[22:0]};
      default: return {r[31], 8'(s[5:0] + 6'd100), r[22:0]};
    endcase
  endfunction

  // ---------------- one transaction on the 4-element instance ----------------
  task automatic run_vec(input vec_t v, input int stall, input string name);
    int b, s, acc, w;
    logic [31:0] ei, ev;
    b  = m_best(v, -1);
    s  = (b < 0) ? -1 : m_best(v, b);
    ei = (b < 0) ? 32'd0 : 32'(b);
    ev = (b < 0) ? v[0] : v[b];

    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) in_data[32*i +: 32] = v[i];
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    acc = cyc;

    // Scramble the input and sometimes keep offering it: both must be ignored.
    @(negedge clk);
    for (int i = 0; i < N; i++) in_data[32*i +: 32] = $urandom();
    in_valid = 1'($urandom_range(0, 1));
    w = 0;
    while (!out_valid && w < 50) begin @(negedge clk); w++; end
    check({name, "_latency"}, 32'(cyc - acc), 32'(N));

    for (int k = 0; k <= stall; k++) begin
      check({name, "_out_valid"}, 32'(out_valid), 32'd1);
      check({name, "_idx"}, 32'(out_index), ei);
      check({name, "_val"}, out_value, ev);
`ifdef NN_CLASSIFIER_RUNNER_UP_EN
      check({name, "_idx2"}, 32'(out_index2), (s < 0) ? 32'd0 : 32'(s));
      check({name, "_val2"}, out_value2, (s < 0) ? QNAN : v[s]);
`endif
      if (k > 0) begin
        check({name, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        check({name, "_stall_busy"}, 32'(busy), 32'd1);
      end
      if (k < stall) @(negedge clk);
    end

    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_rel_in_ready"}, 32'(in_ready), 32'd1);
    check({name, "_rel_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_rel_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t v;
    logic [31:0] one_vals [3];

    // Reset state, asserted from time 0.
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    check("rst_value", out_value, 32'd0);
`ifdef NN_CLASSIFIER_RUNNER_UP_EN
    check("rst_index2", 32'(out_index2), 32'd0);
    check("rst_value2", out_value2, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors (trailing NaNs pad shorter lists; NaN never wins).
    v = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000};
    run_vec(v, 0, "basic");
    v = '{32'hBF800000, 32'hBF000000, 32'hC0000000, 32'h7FC00000};
    run_vec(v, 0, "neg");
    v = '{32'h40000000, 32'h40000000, 32'h7FC00000, 32'h7FC00000};
    run_vec(v, 0, "tie");
    v = '{32'h7FC00000, 32'h80000000, 32'h00000000, 32'h7FC00000};
    run_vec(v, 0, "zeros");
    v = '{32'h7FC00000, 32'h7F800001, 32'hFFC00000, 32'h7FFFFFFF};
    run_vec(v, 0, "allnan");
    v = '{32'h3F000000, 32'h40400000, 32'h3F800000, 32'h40400000};
    run_vec(v, 0, "runner");
    v = '{32'hFF800000, 32'h7F800000, 32'h00000001, 32'h80000001};
    run_vec(v, 0, "inf");
    v = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000};
    run_vec(v, 5, "stall");

    // Reset in the middle of a scan.
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) in_data[32*i +: 32] = 32'h41000000 + 32'(i);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_index", 32'(out_index), 32'd0);
    check("midrst_value", out_value, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{32'hC0000000, 32'h3F800000, 32'h7FC00000, 32'h3F800000};
    run_vec(v, 0, "after_rst");

    // Randomised vectors with duplicates and random output back-pressure.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) v[i] = rnd_fp();
      if ($urandom_range(0, 2) == 0) v[$urandom_range(0, N-1)] = v[$urandom_range(0, N-1)];
      run_vec(v, $urandom_range(0, 2), "rand");
    end

    // Single-element instance: straight to DONE, one cycle latency.
    one_vals = '{32'h3F800000, 32'h7FC00000, 32'hFF800000};
    for (int t = 0; t < 3; t++) begin
      int acc;
      @(negedge clk);
      check("one_in_ready", 32'(in1_ready), 32'd1);
      in1_valid = 1'b1;
      in1_data  = one_vals[t];
      acc = cyc;
      @(negedge clk);
      in1_valid = 1'b0;
      in1_data  = $urandom();
      check("one_latency_valid", 32'(out1_valid), 32'd1);
      check("one_latency", 32'(cyc - acc), 32'd1);
      check("one_idx", 32'(out1_index), 32'd0);
      check("one_val", out1_value, one_vals[t]);
`ifdef NN_CLASSIFIER_RUNNER_UP_EN
      check("one_idx2", 32'(out1_index2), 32'd0);
      check("one_val2", out1_value2, QNAN);
`endif
      out1_ready = 1'b1;
      @(negedge clk);
      out1_ready = 1'b0;
      check("one_rel_in_ready", 32'(in1_ready), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
